// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: ALU control decode and execute stage for the multi-cycle
// MIPS datapath.
//   clk, rst               clock (rising edge), async active-high reset
//   in_valid / in_ready    request handshake; in_ready high only in IDLE
//   alu_op, funct          decoded into the 4-bit ALU control code
//   a, b, shamt            operands and shift amount
//   alu_ctrl, result, zero registered outputs of the last completed op
//   out_valid              one-cycle pulse when the outputs are new
//   illegal                last completed op was undecodable
//   busy                   iterative multiply in progress
//   hi, lo                 multiply result registers
module alu_exec_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SHW    = $clog2(WIDTH),
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             illegal,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    C_AND   = 4'b0000,
    C_OR    = 4'b0001,
    C_ADD   = 4'b0010,
    C_SLL   = 4'b0011,
    C_SRL   = 4'b0100,
    C_SRA   = 4'b0101,
    C_SUB   = 4'b0110,
    C_SLT   = 4'b0111,
    C_SLTU  = 4'b1000,
    C_MULT  = 4'b1001,
    C_MULTU = 4'b1010,
    C_MFHI  = 4'b1011,
    C_NOR   = 4'b1100,
    C_MFLO  = 4'b1101,
    C_NONE  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             r_state, w_state_nxt;
  alu_ctrl_e          w_ctrl;
  logic               w_illegal, w_is_mul, w_fire, w_mul_last;
  logic [WIDTH-1:0]   w_alu, w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_acc_step, w_prod;

  logic [3:0]         r_alu_ctrl;
  logic [WIDTH-1:0]   r_result, r_hi, r_lo, r_mplier;
  logic               r_zero, r_out_valid, r_illegal, r_signed, r_neg;
  logic [2*WIDTH-1:0] r_mcand, r_acc;
  logic [SHW-1:0]     r_cnt;

  // Decode
  always_comb begin
    w_ctrl = C_NONE;
    unique case (alu_op)
      2'b00: w_ctrl = C_ADD;
      2'b01: w_ctrl = C_SUB;
      2'b11: w_ctrl = C_OR;
      default: begin
        case (funct)
          6'b100000: w_ctrl = C_ADD;
          6'b100010: w_ctrl = C_SUB;
          6'b100100: w_ctrl = C_AND;
          6'b100101: w_ctrl = C_OR;
          6'b100111: w_ctrl = C_NOR;
          6'b101010: w_ctrl = C_SLT;
          6'b101011: w_ctrl = C_SLTU;
          6'b000000: w_ctrl = C_SLL;
          6'b000010: w_ctrl = C_SRL;
          6'b000011: w_ctrl = C_SRA;
          6'b011000: w_ctrl = MUL_EN ? C_MULT  : C_NONE;
          6'b011001: w_ctrl = MUL_EN ? C_MULTU : C_NONE;
          6'b010000: w_ctrl = MUL_EN ? C_MFHI  : C_NONE;
          6'b010010: w_ctrl = MUL_EN ? C_MFLO  : C_NONE;
          default:   w_ctrl = C_NONE;
        endcase
      end
    endcase
  end

  assign w_illegal = (w_ctrl == C_NONE);
  assign w_is_mul  = (w_ctrl == C_MULT) || (w_ctrl == C_MULTU);
  assign w_fire    = in_valid && (r_state == S_IDLE);

  // Single-cycle execute
  always_comb begin
    w_alu = '0;
    case (w_ctrl)
      C_AND:   w_alu = a & b;
      C_OR:    w_alu = a | b;
      C_NOR:   w_alu = ~(a | b);
      C_ADD:   w_alu = a + b;
      C_SUB:   w_alu = a - b;
      C_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      C_SLL:   w_alu = b << shamt;
      C_SRL:   w_alu = b >> shamt;
      C_SRA:   w_alu = $signed(b) >>> shamt;
      C_MFHI:  w_alu = r_hi;
      C_MFLO:  w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the sign is reapplied on the final step.
  assign w_a_mag    = (w_ctrl == C_MULT && a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (w_ctrl == C_MULT && b[WIDTH-1]) ? -b : b;
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod     = r_neg ? -w_acc_step : w_acc_step;
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fire && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_ctrl  <= 4'b1111;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_signed    <= 1'b0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_fire) begin
        if (!w_is_mul) begin
          r_alu_ctrl  <= w_ctrl;
          r_illegal   <= w_illegal;
          r_result    <= w_alu;
          r_zero      <= (w_alu == '0);
          r_out_valid <= 1'b1;
        end else begin
          // Visible outputs keep the previous op until the product is ready.
          r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
          r_mplier <= w_b_mag;
          r_acc    <= '0;
          r_signed <= (w_ctrl == C_MULT);
          r_neg    <= (w_ctrl == C_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_cnt    <= '0;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHW'(1);
        if (w_mul_last) begin
          r_hi        <= w_prod[2*WIDTH-1:WIDTH];
          r_lo        <= w_prod[WIDTH-1:0];
          r_result    <= w_prod[WIDTH-1:0];
          r_zero      <= (w_prod[WIDTH-1:0] == '0);
          r_alu_ctrl  <= r_signed ? C_MULT : C_MULTU;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_MUL);
  assign alu_ctrl  = r_alu_ctrl;
  assign result    = r_result;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: self-checking bench for alu_exec_ctrl. Three instances
// (32-bit with multiply, 8-bit with multiply, 8-bit without) share operand
// inputs and are selected one at a time; a behavioural model predicts results.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [4:0]  shamt;

  always #5 clk = ~clk;

  logic        rdy32, z32, ov32, ill32, busy32;
  logic [3:0]  ctrl32;
  logic [31:0] res32, hi32, lo32;
  logic        rdy8, z8, ov8, ill8, busy8;
  logic [3:0]  ctrl8;
  logic [7:0]  res8, hi8, lo8;
  logic        rdyn, zn, ovn, illn, busyn;
  logic [3:0]  ctrln;
  logic [7:0]  resn, hin, lon;

  alu_exec_ctrl #(.WIDTH(32), .MUL_EN(1'b1)) u32 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy32),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .alu_ctrl(ctrl32), .result(res32), .zero(z32), .out_valid(ov32),
    .illegal(ill32), .busy(busy32), .hi(hi32), .lo(lo32));

  alu_exec_ctrl #(.WIDTH(8), .MUL_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy8),
    .alu_op(alu_op), .funct(funct), .a(a[7:0]), .b(b[7:0]), .shamt(shamt[2:0]),
    .alu_ctrl(ctrl8), .result(res8), .zero(z8), .out_valid(ov8),
    .illegal(ill8), .busy(busy8), .hi(hi8), .lo(lo8));

  alu_exec_ctrl #(.WIDTH(8), .MUL_EN(1'b0)) u8n (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdyn),
    .alu_op(alu_op), .funct(funct), .a(a[7:0]), .b(b[7:0]), .shamt(shamt[2:0]),
    .alu_ctrl(ctrln), .result(resn), .zero(zn), .out_valid(ovn),
    .illegal(illn), .busy(busyn), .hi(hin), .lo(lon));

  int          sel = 0;
  logic        o_rdy, o_z, o_ov, o_ill, o_busy;
  logic [3:0]  o_ctrl;
  logic [31:0] o_res, o_hi, o_lo;

  always_comb begin
    o_rdy = rdy32; o_z = z32; o_ov = ov32; o_ill = ill32; o_busy = busy32;
    o_ctrl = ctrl32; o_res = res32; o_hi = hi32; o_lo = lo32;
    if (sel == 1) begin
      o_rdy = rdy8; o_z = z8; o_ov = ov8; o_ill = ill8; o_busy = busy8;
      o_ctrl = ctrl8; o_res = {24'b0, res8}; o_hi = {24'b0, hi8}; o_lo = {24'b0, lo8};
    end else if (sel == 2) begin
      o_rdy = rdyn; o_z = zn; o_ov = ovn; o_ill = illn; o_busy = busyn;
      o_ctrl = ctrln; o_res = {24'b0, resn}; o_hi = {24'b0, hin}; o_lo = {24'b0, lon};
    end
  end

  int n_err = 0;
  int n_chk = 0;
  longint unsigned mhi [3];
  longint unsigned mlo [3];
  longint unsigned last_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: MIPS semantics via plain integer arithmetic at width w.
  function automatic void model(input int w, input bit me, input logic [1:0] op,
                                input logic [5:0] fn, input longint unsigned x,
                                input longint unsigned y, input int sh,
                                inout longint unsigned mh, inout longint unsigned ml,
                                output logic [3:0] ctrl, output longint unsigned res,
                                output bit ill, output bit mul);
    longint unsigned m, m2, full;
    longint sx, sy;
    m  = (64'd1 << w) - 1;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 1);
    sx = x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
    sy = y[w-1] ? (longint'(y) - (longint'(1) << w)) : longint'(y);
    ctrl = 4'hF; res = 0; mul = 1'b0; full = 0;
    case (op)
      2'd0: begin ctrl = 4'h2; res = (x + y) & m; end
      2'd1: begin ctrl = 4'h6; res = (x - y) & m; end
      2'd3: begin ctrl = 4'h1; res = x | y; end
      default: begin
        case (fn)
          6'h20: begin ctrl = 4'h2; res = (x + y) & m; end
          6'h22: begin ctrl = 4'h6; res = (x - y) & m; end
          6'h24: begin ctrl = 4'h0; res = x & y; end
          6'h25: begin ctrl = 4'h1; res = x | y; end
          6'h27: begin ctrl = 4'hC; res = ~(x | y) & m; end
          6'h2a: begin ctrl = 4'h7; res = (sx < sy) ? 1 : 0; end
          6'h2b: begin ctrl = 4'h8; res = (x < y) ? 1 : 0; end
          6'h00: begin ctrl = 4'h3; res = (y << sh) & m; end
          6'h02: begin ctrl = 4'h4; res = y >> sh; end
          6'h03: begin ctrl = 4'h5; res = longint'(sy >>> sh) & m; end
          6'h18: if (me) begin ctrl = 4'h9; mul = 1'b1; full = longint'(sx * sy) & m2; end
          6'h19: if (me) begin ctrl = 4'hA; mul = 1'b1; full = (x * y) & m2; end
          6'h10: if (me) begin ctrl = 4'hB; res = mh; end
          6'h12: if (me) begin ctrl = 4'hD; res = ml; end
          default: ctrl = 4'hF;
        endcase
      end
    endcase
    ill = (ctrl == 4'hF);
    if (mul) begin
      mh  = (full >> w) & m;
      ml  = full & m;
      res = ml;
    end
  endfunction

  // One request to instance s; a multiply also keeps an add request pending
  // while busy, which must be taken only once in_ready returns.
  task automatic run_op(input int s, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] ai, input logic [31:0] bi, input logic [4:0] shi);
    int w;
    logic [3:0] ec;
    longint unsigned er, h, l, m, ea;
    bit eil, emul;
    w = (s == 0) ? 32 : 8;
    m = (64'd1 << w) - 1;
    h = mhi[s];
    l = mlo[s];
    model(w, s != 2, op, fn, longint'(ai) & m, longint'(bi) & m,
          (s == 0) ? int'(shi) : int'(shi) & 7, h, l, ec, er, eil, emul);
    sel = s;
    @(negedge clk);
    alu_op = op; funct = fn; a = ai; b = bi; shamt = shi; vld[s] = 1'b1;
    #1 check("ready_before", o_rdy, 1);
    @(posedge clk); #1;
    if (!emul) begin
      vld[s] = 1'b0;
      check("ov", o_ov, 1);
      check("ctrl", o_ctrl, ec);
      check("result", o_res, er);
      check("zero", o_z, er == 0);
      check("illegal", o_ill, eil);
      check("busy_single", o_busy, 0);
      last_res = er;
    end else begin
      alu_op = 2'b00;
      for (int k = 0; k < w; k++) begin
        check("mul_busy", o_busy, 1);
        check("mul_ready", o_rdy, 0);
        check("mul_ov", o_ov, 0);
        @(posedge clk); #1;
      end
      mhi[s] = h;
      mlo[s] = l;
      check("mul_done_ov", o_ov, 1);
      check("mul_ctrl", o_ctrl, ec);
      check("mul_result", o_res, er);
      check("mul_zero", o_z, er == 0);
      check("mul_hi", o_hi, h);
      check("mul_lo", o_lo, l);
      check("mul_ready_done", o_rdy, 1);
      check("mul_illegal", o_ill, 0);
      @(posedge clk); #1;
      vld[s] = 1'b0;
      ea = (longint'(ai) + longint'(bi)) & m;
      check("held_add_ov", o_ov, 1);
      check("held_add_ctrl", o_ctrl, 4'h2);
      check("held_add_result", o_res, ea);
      last_res = ea;
    end
  endtask

  logic [5:0] fn_tab [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
                              6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};

  initial begin
    int ov_seen;
    rst = 1'b0; vld = '0; alu_op = '0; funct = '0; a = '0; b = '0; shamt = '0;
    for (int i = 0; i < 3; i++) begin mhi[i] = 0; mlo[i] = 0; end

    // Reset asserted mid-cycle takes effect immediately
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_ctrl", o_ctrl, 4'hF);
    check("rst_result", o_res, 0);
    check("rst_zero", o_z, 1);
    check("rst_ov", o_ov, 0);
    check("rst_ready", o_rdy, 1);
    check("rst_hi", o_hi, 0);
    check("rst_lo", o_lo, 0);
    check("rst_illegal", o_ill, 0);
    @(negedge clk); rst = 1'b0;

    // sub then slt back-to-back
    run_op(0, 2'b10, 6'b100010, 32'd5, 32'd7, 5'd0);
    check("t2_sub_const", o_res, 64'hFFFF_FFFE);
    run_op(0, 2'b10, 6'b101010, 32'd5, 32'd7, 5'd0);
    check("t2_slt_const", o_res, 64'd1);

    // shifts
    run_op(0, 2'b10, 6'b000011, 32'd0, 32'h8000_0000, 5'd4);
    check("t3_sra_const", o_res, 64'hF800_0000);
    run_op(0, 2'b10, 6'b000010, 32'd0, 32'h8000_0000, 5'd4);
    check("t3_srl_const", o_res, 64'h0800_0000);

    // 8-bit signed multiply, then mfhi
    run_op(1, 2'b10, 6'b011000, 32'hFD, 32'h05, 5'd0);
    check("t4_hi_const", o_hi, 64'hFF);
    check("t4_lo_const", o_lo, 64'hF1);
    run_op(1, 2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    check("t4_mfhi_const", o_res, 64'hFF);

    // unsigned multiply, then one aborted by reset
    run_op(1, 2'b10, 6'b011001, 32'hFF, 32'hFF, 5'd0);
    check("t5_hi_const", o_hi, 64'hFE);
    check("t5_lo_const", o_lo, 64'h01);
    sel = 1;
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011001; a = 32'h7F; b = 32'h3; vld[1] = 1'b1;
    @(posedge clk); #1 vld[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_hi", o_hi, 0);
    check("abort_lo", o_lo, 0);
    check("abort_ready", o_rdy, 1);
    check("abort_busy", o_busy, 0);
    check("abort_ov", o_ov, 0);
    for (int i = 0; i < 3; i++) begin mhi[i] = 0; mlo[i] = 0; end
    @(negedge clk); rst = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_ov) ov_seen++;
    end
    check("abort_no_ov", ov_seen, 0);

    // illegal functs
    run_op(0, 2'b10, 6'b111111, 32'h1234, 32'h5678, 5'd0);
    check("t6_illegal_const", o_ill, 1);
    run_op(2, 2'b10, 6'b011000, 32'h12, 32'h34, 5'd0);
    check("t6_nomul_illegal", o_ill, 1);
    check("t6_nomul_ctrl", o_ctrl, 4'hF);

    // randomized mix
    for (int n = 0; n < 150; n++) begin
      int s, r;
      logic [1:0] op;
      logic [5:0] fn;
      logic [31:0] ra, rb;
      s  = $urandom_range(0, 2);
      r  = $urandom_range(0, 7);
      op = (r < 5) ? 2'b10 : 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 13)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(s, op, fn, ra, rb, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("idle_ov_low", o_ov, 0);
        check("idle_hold_result", o_res, last_res);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Parametrised ALU control and execute stage for the multi-cycle MIPS datapath. It decodes ALUOp/funct into a 4-bit ALU control code and executes the operation on registered operands. Single-cycle ops complete with 1-cycle latency. MULT/MULTU run on an iterative shift-add engine that writes HI/LO, with a valid/ready handshake to the control FSM.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
MUL_EN, 1, 1 = MULT/MULTU/MFHI/MFLO supported; 0 = those functs are illegal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept; high only in IDLE
alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type by funct, 11 or (ori)
funct  in  6  R-type function field
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt / immediate
shamt  in  SHW  shift amount
alu_ctrl  out  4  registered control code of the last accepted op
result  out  WIDTH  registered result
zero  out  1  result == 0, registered with result
out_valid  out  1  one-cycle pulse: result/alu_ctrl/zero are new
illegal  out  1  registered; last accepted op was undecodable
busy  out  1  multiply in progress
hi, lo  out  WIDTH  multiply result registers

Behaviour:
- Reset (async): state IDLE; alu_ctrl=4'b1111; result=0; zero=1; out_valid=0; illegal=0; hi=lo=0; iteration counter=0. Reset during MUL aborts the multiply; HI/LO are not written.
- Codes: and 0000, or 0001, add 0010, sll 0011, srl 0100, sra 0101, sub 0110, slt 0111, sltu 1000, mult 1001, multu 1010, mfhi 1011, nor 1100, mflo 1101, none/illegal 1111.
- funct decode (alu_op=10): 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 101011 sltu, 000000 sll, 000010 srl, 000011 sra, 011000 mult, 011001 multu, 010000 mfhi, 010010 mflo.
- Any other funct: alu_ctrl=1111, result=0, illegal=1, out_valid pulses. MUL_EN=0 makes the four mul functs illegal.
- Accept: handshake completes on a rising edge with in_valid && in_ready. in_valid while in_ready=0 is ignored; no queuing.
- Single-cycle ops (IDLE→IDLE): registers update at the accept edge and out_valid=1 for the following cycle. Latency 1. Back-to-back accepts every cycle are allowed.
- Arithmetic: add/sub are modulo 2^WIDTH with no overflow trap. slt is signed and sltu unsigned; both give result 0 or 1. sll/srl/sra shift b by shamt (sra sign-fills). mfhi/mflo copy hi/lo.
- MUL FSM: IDLE→MUL at the accept edge. busy=1, in_ready=0, operands latched (MULT uses |a|,|b| plus the sign XOR). One partial-product bit per cycle, counter 0..WIDTH-1.
- MUL completion: at the WIDTH-th edge after accept, {hi,lo} = 2·WIDTH-bit product (negated if signed and the XOR is set), result=lo, zero=(lo==0), out_valid pulses, state→IDLE. in_ready is high that same cycle.
- MUL latency: WIDTH cycles.
- alu_ctrl, result, zero and illegal hold their values between out_valid pulses.

Test Plan:
1. Reset asserted mid-cycle → outputs immediately alu_ctrl=1111, result=0, zero=1, out_valid=0, in_ready=1, hi=lo=0.
2. WIDTH=32, alu_op=10: funct 100010 with a=5, b=7 → result=0xFFFFFFFE, zero=0, ctrl 0110. Next cycle funct 101010, same operands → result=1, ctrl 0111. Two consecutive out_valid pulses.
3. funct 000011, b=0x80000000, shamt=4 → result=0xF8000000. funct 000010, same operands → 0x08000000.
4. WIDTH=8, funct 011000, a=0xFD(-3), b=0x05 → busy/in_ready=0 for 8 cycles; then hi=0xFF, lo=0xF1, out_valid pulses at latency 8. in_valid held with add during busy is not accepted until in_ready=1. Then mfhi → result=0xFF.
5. WIDTH=8 multu 0xFF*0xFF → hi=0xFE, lo=0x01. A second multu with rst pulsed at cycle 3 → hi=lo=0, state IDLE, no out_valid.
6. funct 111111 → illegal=1, ctrl 1111, result=0. With MUL_EN=0, funct 011000 → illegal=1 with latency 1.
